clock_tick_scheduler: RTL and testbench
=======================================

# clock_tick_scheduler

Shares one free-running `divided_clocks` bus among `NUM_CH` consumers. Each channel is configured at runtime with a tap index and an enable. For each enabled channel, the block produces a single-cycle `tick` strobe on every rising edge of the selected divider bit. Consumers use these strobes as clock enables on the main clock, which keeps all logic in one clock domain. The block sits directly downstream of the clock divider and is configured by a small valid/ready write port.

## Interface
- `NUM_CH`, default 4: number of tick channels, 1..16.
- `TAP_W`, default 5: tap index width; selects bit 0..31 of `divided_clocks`.
- `clock`  in  1: system clock; all logic on the posedge.
- `reset`  in  1: synchronous, active-high reset.
- `divided_clocks`  in  32: free-running divider count, sampled every `clock`.
- `cfg_valid`  in  1: configuration write request.
- `cfg_ready`  out  1: block can accept a configuration write.
- `cfg_ch`  in  4: target channel index.
- `cfg_tap`  in  TAP_W: tap bit for the target channel.
- `cfg_en`  in  1: 1 = enable the channel, 0 = disable it.
- `cfg_err`  out  1: one-cycle pulse when an accepted write had `cfg_ch >= NUM_CH`.
- `tick`  out  NUM_CH: per-channel one-cycle strobe.
- `running`  out  NUM_CH: per-channel flag, 1 while the channel is in state RUN.

## Operation
- **Per-channel state machine:** states OFF, ARM, RUN. Per-channel registers: `tap`, `prev_bit`, `state`.
- **Current bit:** `cur = divided_clocks[tap]`.
- **OFF:** `tick` = 0. The channel leaves OFF only through a configuration write with `cfg_en` = 1.
- **ARM:**
  - `tick` = 0.
  - If `cur` = 0, go to RUN and set `prev_bit` to 0.
  - Otherwise stay in ARM.
  - Purpose: a channel never ticks on the partial high phase that was in progress when it was enabled.
- **RUN:** each cycle, `tick[c] <= cur & ~prev_bit` and `prev_bit <= cur`.
- **Configuration handshake:**
  - A transfer occurs on a cycle where `cfg_valid` and `cfg_ready` are both 1.
  - In the next cycle, `cfg_ready` is 0 (apply cycle). It returns to 1 the cycle after that.
  - Minimum spacing between accepted writes is therefore 2 cycles.
- **Effect of an accepted write to a valid channel** (visible in the apply cycle):
  - `tap <= cfg_tap`.
  - `state <= cfg_en ? ARM : OFF`.
  - That channel's `tick` is forced to 0 in the apply cycle.
  - Other channels are unaffected.
- **Writes to an already-running channel:** re-arm it. A new tap never produces a tick from a stale `prev_bit`.
- **Invalid channel:** a write with `cfg_ch >= NUM_CH` is still accepted. No channel changes, and `cfg_err` = 1 in the apply cycle.
- **Width rules:** `cfg_tap` is used modulo 32. With `TAP_W` = 5 there is no truncation. Upper bits of `cfg_ch` beyond `log2(NUM_CH)` participate in the range check; they are not ignored.

## Timing
- **Reset values:**
  - All states OFF; `tap` = 0; `prev_bit` = 0.
  - `tick` = 0, `running` = 0, `cfg_err` = 0.
  - `cfg_ready` = 1 in the first cycle after `reset` deasserts.
- **Reset mid-operation:** reset overrides everything, including an in-flight apply cycle. A write presented in the same cycle as `reset` is discarded.
- **Tick latency:** if `divided_clocks[tap]` is sampled 0 at edge k and 1 at edge k+1, `tick` is high for exactly the cycle following edge k+1. Latency is 1 registered cycle.
- **Tick period:** for tap n with a counter incrementing every cycle, ticks are exactly 2^(n+1) cycles apart.
- **Tap 0 boundary:** bit 0 toggles every cycle, so tap 0 ticks every 2nd cycle and never on consecutive cycles.
- **ARM→RUN cost:** 1 cycle after `cur` = 0 is observed. The first tick follows the next 0→1 transition.
- **Counter wrap-around:** when `divided_clocks` wraps from `FFFF_FFFF` to 0, tap 31 falls 1→0, which produces no tick. Every other tap follows its normal pattern; no special case.
- **`running`:** combinational decode of state, so it is 1 in the same cycle that state = RUN.
- **Simultaneous events:** any number of channels may tick in the same cycle. A configuration write to channel A does not delay or suppress a tick on channel B.

## Test plan
Bench conditions: `NUM_CH` = 4; `divided_clocks` driven by a bench counter that increments every clock starting at 0.

- **Reset:** hold `reset` 3 cycles → `tick` = 0000, `running` = 0000, `cfg_err` = 0; `cfg_ready` = 1 the cycle after release.
- **Tap 0:** write ch0 tap 0 en 1 → `cfg_ready` low for exactly 1 cycle; `tick[0]` pulses every 2 cycles, 1 cycle wide, 20 pulses in 40 cycles.
- **Tap 2 while bit high:** write ch1 tap 2 en 1 at a time when bit 2 = 1 → channel stays ARM with no tick until bit 2 = 0. First tick follows the next 3→4 count transition; later ticks are exactly 8 cycles apart.
- **Retap and disable:**
  - Retap running ch1 to tap 3 → no tick in the apply cycle; ticks then 16 cycles apart.
  - Write ch1 en 0 → `running[1]` = 0 and no further ticks.
- **Invalid channel:** write `cfg_ch` = 7 → `cfg_err` pulses exactly 1 cycle; all `tick`/`running` patterns unchanged.
- **Reset mid-write:** assert `cfg_valid` for ch2 in the same cycle as `reset` → after reset, ch2 is OFF and `tick[2]` stays 0 for 64 cycles.

Source files
------------

// File: rtl/clock_tick_scheduler.sv
// Per-channel tick strobes derived from rising edges of a selectable bit of a shared
// free-running divider count. Configured through a valid/ready write port.
module clock_tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int TAP_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       divided_clocks,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [TAP_W-1:0]  cfg_tap,
    input  logic              cfg_en,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    localparam logic [1:0] ST_OFF = 2'd0;
    localparam logic [1:0] ST_ARM = 2'd1;
    localparam logic [1:0] ST_RUN = 2'd2;
    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    logic [NUM_CH-1:0][1:0] state_q, state_d;
    logic [NUM_CH-1:0][4:0] tap_q, tap_d;
    logic [NUM_CH-1:0]      prev_bit_q, prev_bit_d;
    logic [NUM_CH-1:0]      tick_q, tick_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   cfg_err_q, cfg_err_d;

    logic                   cfg_fire_s;
    logic                   cfg_ch_ok_s;
    logic [4:0]             cfg_tap_s;
    logic [NUM_CH-1:0]      cur_s;

    // The tap index always addresses a 32-bit bus, so only its low five bits matter.
    if (TAP_W >= 5) begin : g_tap_trunc
        assign cfg_tap_s = cfg_tap[4:0];
    end else begin : g_tap_ext
        assign cfg_tap_s = {{(5 - TAP_W){1'b0}}, cfg_tap};
    end

    // Selected divider bit for every channel.
    always_comb begin
        cur_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            cur_s[c] = divided_clocks[tap_q[c]];
        end
    end

    // Handshake, range check and per-channel OFF/ARM/RUN next state.
    always_comb begin
        cfg_fire_s  = cfg_valid & cfg_ready_q;
        cfg_ch_ok_s = ({1'b0, cfg_ch} < NUM_CH_L);
        cfg_ready_d = ~cfg_fire_s;
        cfg_err_d   = cfg_fire_s & ~cfg_ch_ok_s;
        state_d     = state_q;
        tap_d       = tap_q;
        prev_bit_d  = prev_bit_q;
        tick_d      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_fire_s && cfg_ch_ok_s && (cfg_ch == 4'(c))) begin
                // Any write re-arms, so a new tap never compares against a stale prev_bit.
                tap_d[c]      = cfg_tap_s;
                state_d[c]    = cfg_en ? ST_ARM : ST_OFF;
                prev_bit_d[c] = 1'b0;
            end else begin
                case (state_q[c])
                    ST_OFF: begin
                        state_d[c] = ST_OFF;
                    end
                    ST_ARM: begin
                        if (!cur_s[c]) begin
                            state_d[c]    = ST_RUN;
                            prev_bit_d[c] = 1'b0;
                        end else begin
                            state_d[c] = ST_ARM;
                        end
                    end
                    ST_RUN: begin
                        tick_d[c]     = cur_s[c] & ~prev_bit_q[c];
                        prev_bit_d[c] = cur_s[c];
                    end
                    default: begin
                        state_d[c]    = ST_OFF;
                        prev_bit_d[c] = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset also discards any write presented alongside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= {NUM_CH{ST_OFF}};
            tap_q       <= '0;
            prev_bit_q  <= '0;
            tick_q      <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            prev_bit_q  <= prev_bit_d;
            tick_q      <= tick_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Running flags decode the current state directly.
    always_comb begin
        running = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            running[c] = (state_q[c] == ST_RUN);
        end
    end

    assign tick      = tick_q;
    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Scoreboard bench for clock_tick_scheduler: a behavioural model queues the expected
// outputs per clock edge and a monitor compares them on the falling edge.
module tb_clock_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int TAP_W  = 5;

    typedef enum logic [1:0] {M_OFF, M_ARM, M_RUN} mode_t;

    typedef struct packed {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] running;
        logic              ready;
        logic              err;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       divided_clocks = 32'd0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_ch = 4'd0;
    logic [TAP_W-1:0]  cfg_tap = 5'd0;
    logic              cfg_en = 1'b0;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;

    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    exp_t exp_q[$];

    mode_t       m_mode[NUM_CH];
    logic [4:0]  m_tap[NUM_CH];
    logic        m_ready = 1'b1;
    logic [31:0] last_cnt = 32'd0;

    clock_tick_scheduler #(.NUM_CH(NUM_CH), .TAP_W(TAP_W)) dut (
        .clock(clock), .reset(reset), .divided_clocks(divided_clocks),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_tap(cfg_tap), .cfg_en(cfg_en), .cfg_err(cfg_err),
        .tick(tick), .running(running)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict outputs after the coming edge from the inputs now on the pins, then clock.
    task automatic step();
        exp_t e;
        logic acc;
        e = '0;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_mode[c] = M_OFF;
                m_tap[c]  = 5'd0;
            end
            m_ready = 1'b1;
        end else begin
            acc = cfg_valid && m_ready;
            for (int c = 0; c < NUM_CH; c++) begin
                if (acc && (int'(cfg_ch) == c)) begin
                    m_tap[c]  = cfg_tap;
                    m_mode[c] = cfg_en ? M_ARM : M_OFF;
                end else if (m_mode[c] == M_ARM) begin
                    if (divided_clocks[m_tap[c]] == 1'b0) m_mode[c] = M_RUN;
                end else if (m_mode[c] == M_RUN) begin
                    e.tick[c] = divided_clocks[m_tap[c]] && !last_cnt[m_tap[c]];
                end
            end
            e.err   = acc && (int'(cfg_ch) >= NUM_CH);
            m_ready = !acc;
        end
        e.ready = m_ready;
        for (int c = 0; c < NUM_CH; c++) e.running[c] = (m_mode[c] == M_RUN);
        last_cnt = divided_clocks;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        divided_clocks = divided_clocks + 32'd1;
    endtask

    task automatic write(input logic [3:0] ch, input logic [4:0] tap, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_tap   = tap;
        cfg_en    = en;
        step();
        cfg_valid = 1'b0;
    endtask

    // Monitor: one expected entry per edge, compared mid-cycle.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_tick", 32'(tick), 32'(e.tick));
                chk("sb_running", 32'(running), 32'(e.running));
                chk("sb_cfg_ready", 32'(cfg_ready), 32'(e.ready));
                chk("sb_cfg_err", 32'(cfg_err), 32'(e.err));
            end else if (!done) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got 0 entries expected 1 at %0t", $time);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int last;
        for (int c = 0; c < NUM_CH; c++) begin
            m_mode[c] = M_OFF;
            m_tap[c]  = 5'd0;
        end

        // Reset held three cycles.
        reset = 1'b1;
        repeat (3) step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        step();
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        repeat (2) step();

        // Tap 0 on channel 0.
        write(4'd0, 5'd0, 1'b1);
        chk("tap0_ready_low", 32'(cfg_ready), 32'd0);
        step();
        chk("tap0_ready_back", 32'(cfg_ready), 32'd1);
        repeat (3) step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick[0]) n++;
        end
        chk("tap0_count40", 32'(n), 32'd20);

        // Tap 2 on channel 1, written while bit 2 is high.
        for (int i = 0; i < 16 && divided_clocks[2] == 1'b0; i++) step();
        write(4'd1, 5'd2, 1'b1);
        n = 0;
        last = -1;
        for (int i = 0; i < 48; i++) begin
            step();
            if (tick[1]) begin
                chk("tap2_phase", (divided_clocks - 32'd1) & 32'd7, 32'd4);
                if (last >= 0) chk("tap2_gap", 32'(i - last), 32'd8);
                last = i;
                n++;
            end
        end
        chk("tap2_enough", 32'(n >= 5), 32'd1);

        // Retap channel 1 to tap 3, then disable it.
        write(4'd1, 5'd3, 1'b1);
        chk("retap_apply_tick", 32'(tick[1]), 32'd0);
        n = 0;
        last = -1;
        for (int i = 0; i < 64; i++) begin
            step();
            if (tick[1]) begin
                chk("tap3_phase", (divided_clocks - 32'd1) & 32'd15, 32'd8);
                if (last >= 0) chk("tap3_gap", 32'(i - last), 32'd16);
                last = i;
                n++;
            end
        end
        chk("tap3_enough", 32'(n >= 3), 32'd1);
        write(4'd1, 5'd3, 1'b0);
        n = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (tick[1]) n++;
        end
        chk("dis_ticks", 32'(n), 32'd0);
        chk("dis_running", 32'(running[1]), 32'd0);

        // Invalid channel indices, including upper cfg_ch bits.
        write(4'd7, 5'd1, 1'b1);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        step();
        chk("err_clear", 32'(cfg_err), 32'd0);
        write(4'd12, 5'd1, 1'b1);
        chk("err_pulse_hi", 32'(cfg_err), 32'd1);
        repeat (4) step();

        // Randomised configuration traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch    = 4'($urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(4, 15));
            cfg_tap   = 5'($urandom_range(0, 5));
            cfg_en    = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            step();
        end
        cfg_valid = 1'b0;
        reset = 1'b0;
        repeat (2) step();

        // Counter wrap: tap 31 falls at the wrap and must not tick.
        divided_clocks = 32'hFFFF_FFF0;
        write(4'd3, 5'd31, 1'b1);
        step();
        write(4'd2, 5'd4, 1'b1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tick[3]) n++;
        end
        chk("wrap_tap31_ticks", 32'(n), 32'd0);
        chk("wrap_tap31_running", 32'(running[3]), 32'd1);

        // Write coincident with reset is discarded.
        reset = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch = 4'd2;
        cfg_tap = 5'd0;
        cfg_en = 1'b1;
        step();
        reset = 1'b0;
        cfg_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (tick[2]) n++;
        end
        chk("rstwr_ticks", 32'(n), 32'd0);
        chk("rstwr_running", 32'(running[2]), 32'd0);

        @(negedge clock);
        #1;
        done = 1'b1;
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
